prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that writes 19-bit instruction words into the instruction memory write port and holds the CPU core in reset until a complete, checksum-verified image is loaded. It is the writer side of instruction memory: the core fetches one word per cycle by address, and this block fills that memory from an external 8-bit source such as a UART receiver or debug bridge. A successful load releases the core, which then starts executing at PC 0.

## Interface
- ADDR_W, 10: instruction memory address width; depth is 2^ADDR_W words.
- TIMEOUT, 65535: maximum idle cycles allowed between bytes inside a frame; minimum 1.
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  a byte is presented on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; equals rst, so it is 0 during reset and 1 otherwise.
- im_we  output  1  instruction memory write strobe, one-cycle pulse.
- im_addr  output  ADDR_W  instruction memory write address.
- im_wdata  output  19  instruction word to write.
- cpu_rst_n  output  1  core reset, active-low; 1 only in DONE.
- done  output  1  image loaded and verified.
- error  output  1  frame rejected.

## Operation
- A byte is accepted on a rising clk edge when in_valid and in_ready are both 1.
- Frame format:
  - 0xA5 sync byte.
  - LEN_H and LEN_L: word count N, 16 bits, big-endian.
  - N words of 3 bytes each, big-endian: B0[2:0] = word[18:16], B1 = word[15:8], B2 = word[7:0].
  - CHK: XOR of LEN_H, LEN_L and all word bytes. The sync byte is not included.
- States: IDLE, LEN_H, LEN_L, B0, B1, B2, CHK, DONE, ERR.
- IDLE:
  - 0xA5 moves to LEN_H.
  - Any other byte is discarded.
- LEN_H to LEN_L: load the length bytes and seed the running XOR with them.
- LEN_L checks:
  - N == 0 or N > 2^ADDR_W goes to ERR.
  - Otherwise the word counter is cleared to 0 and the state moves to B0.
- B0 check: B0[7:3] != 0 goes to ERR.
- Each accepted B2:
  - Writes the word at im_addr = word counter, then increments the counter.
  - After word N the state moves to CHK; otherwise it returns to B0.
- CHK:
  - Byte equal to the running XOR goes to DONE.
  - Mismatch goes to ERR.
  - Words already written stay in memory; the core stays held.
- DONE and ERR:
  - A 0xA5 byte starts a new frame (moves to LEN_H), clears done and error, and drives cpu_rst_n to 0.
  - Other bytes are ignored.
- Timeout: in LEN_H, LEN_L, B0, B1, B2 or CHK, TIMEOUT consecutive cycles with no accepted byte go to ERR. The idle counter resets on every accepted byte. There is no timeout in IDLE, DONE or ERR.
- Output decode:
  - cpu_rst_n = 1 only in DONE.
  - done = (state == DONE).
  - error = (state == ERR).

## Timing
- Reset (rst = 0 at a clk edge):
  - State goes to IDLE.
  - im_we = 0, im_addr = 0, im_wdata = 0.
  - cpu_rst_n = 0, done = 0, error = 0.
  - Word counter, idle counter and XOR are cleared.
  - in_ready = 0 while rst = 0.
- Reset during a frame aborts it. Partial memory contents are left as written; im_we is never asserted after the reset edge.
- Back-to-back bytes (in_valid held at 1) are accepted every cycle, so a full word takes 3 cycles.
- im_we, im_addr and im_wdata are registered. They are valid in the cycle immediately after the B2 handshake edge, and im_we lasts exactly 1 cycle. im_addr and im_wdata hold their values until the next write.
- Transitions into DONE and ERR take effect on the handshake edge (or timeout edge). done, error and cpu_rst_n change in the following cycle.
- With TIMEOUT = T, the error asserts on the T-th consecutive cycle without a handshake; T-1 idle cycles are tolerated.
- Width rules:
  - N is compared as an unsigned 17-bit value against 2^ADDR_W.
  - The word counter is ADDR_W+1 bits wide.
  - im_addr is the low ADDR_W bits of the counter.
  - N = 2^ADDR_W writes the last address 2^ADDR_W - 1 without wrapping.

## Test plan
- Good load: stream A5 00 02 01 23 45 06 78 9A 81 at one byte per cycle.
  - im_we pulses at addr 0 with 0x12345, then at addr 1 with 0x6789A.
  - done = 1, cpu_rst_n = 1, error = 0.
- Bad checksum: same frame with CHK = 0x80.
  - Both writes still occur.
  - error = 1, cpu_rst_n stays 0.
  - A subsequent good frame reaches DONE.
- Format errors:
  - LEN = 0x0000 goes to ERR with no im_we.
  - LEN = 0x0401 with ADDR_W = 10 goes to ERR.
  - B0 = 0x08 goes to ERR.
- Timeout, with TIMEOUT = 4: stall in_valid after B1.
  - 3 idle cycles followed by B2 completes the word normally.
  - 4 idle cycles set error = 1 and produce no write.
- Reset mid-frame: pull rst low after the 4th word byte.
  - All outputs take their reset values; no im_we.
  - Leading garbage 00 FF before a good A5 frame is ignored and the load completes.
- Full depth, with ADDR_W = 4: 16 words with valid gaps inserted.
  - Last write goes to addr 15.
  - done = 1 with no wrap to addr 0.

Source files
------------

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and instruction-memory write bundle for prog_loader
//
// Signals:
//   in_valid, in_data  : byte source -> loader
//   in_ready           : loader -> byte source
//   im_we, im_addr, im_wdata : loader -> instruction memory write port
//   cpu_rst_n, done, error   : loader status and core reset
// Modports: slave = loader side, master = source/observer side.
interface prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [18:0]       im_wdata;
    logic              cpu_rst_n;
    logic              done;
    logic              error;

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_rst_n, done, error
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_rst_n, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader filling instruction memory and gating core reset
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : prog_loader_if.slave (byte stream in, memory write port and status out)
// Parameters:
//   ADDR_W  : instruction memory address width (depth 2^ADDR_W words)
//   TIMEOUT : idle cycles between bytes inside a frame before the frame is rejected (>= 1)
module prog_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);
    localparam int          CW    = ADDR_W + 1;
    localparam int          IW    = $clog2(TIMEOUT + 1);
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_B0, S_B1, S_B2, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idle_q;
    logic [7:0]        xor_q;
    logic [2:0]        b0_q;
    logic [7:0]        b1_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [18:0]       im_wdata_q;
    logic              done_q, error_q, cpu_rst_n_q;

    logic              hs;
    logic              in_frame;
    logic              timed_out;
    logic [15:0]       len_n;
    logic [CW-1:0]     cnt_inc;

    assign bus.in_ready  = rst;
    assign bus.im_we     = im_we_q;
    assign bus.im_addr   = im_addr_q;
    assign bus.im_wdata  = im_wdata_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.cpu_rst_n = cpu_rst_n_q;

    assign hs        = bus.in_valid & rst;
    // Full length as it will be once the low byte currently on the bus is taken.
    assign len_n     = {len_q[15:8], bus.in_data};
    assign cnt_inc   = cnt_q + CW'(1);
    assign in_frame  = state_q inside {S_LEN_H, S_LEN_L, S_B0, S_B1, S_B2, S_CHK};
    // idle_q counts edges already missed; this edge would be the TIMEOUT-th.
    assign timed_out = in_frame && !hs && (idle_q == IW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        if (timed_out) begin
            state_d = S_ERR;
        end else if (hs) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: if (bus.in_data == 8'hA5) state_d = S_LEN_H;
                S_LEN_H: state_d = S_LEN_L;
                S_LEN_L: begin
                    if (len_n == 16'd0 || {1'b0, len_n} > DEPTH) state_d = S_ERR;
                    else                                         state_d = S_B0;
                end
                S_B0:    state_d = (bus.in_data[7:3] != 5'd0) ? S_ERR : S_B1;
                S_B1:    state_d = S_B2;
                // Counter is one bit wider than the address so N = depth ends cleanly.
                S_B2:    state_d = (17'(cnt_inc) == {1'b0, len_q}) ? S_CHK : S_B0;
                S_CHK:   state_d = (bus.in_data == xor_q) ? S_DONE : S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            xor_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            im_we_q     <= 1'b0;
            done_q      <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERR);
            cpu_rst_n_q <= (state_d == S_DONE);

            if (hs)            idle_q <= '0;
            else if (in_frame) idle_q <= idle_q + IW'(1);

            if (hs) begin
                case (state_q)
                    S_LEN_H: begin
                        len_q[15:8] <= bus.in_data;
                        xor_q       <= bus.in_data;
                    end
                    S_LEN_L: begin
                        len_q[7:0] <= bus.in_data;
                        xor_q      <= xor_q ^ bus.in_data;
                        cnt_q      <= '0;
                    end
                    S_B0: begin
                        b0_q  <= bus.in_data[2:0];
                        xor_q <= xor_q ^ bus.in_data;
                    end
                    S_B1: begin
                        b1_q  <= bus.in_data;
                        xor_q <= xor_q ^ bus.in_data;
                    end
                    S_B2: begin
                        im_we_q    <= 1'b1;
                        im_addr_q  <= cnt_q[ADDR_W-1:0];
                        im_wdata_q <= {b0_q, b1_q, bus.in_data};
                        cnt_q      <= cnt_inc;
                        xor_q      <= xor_q ^ bus.in_data;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader with a frame-position reference model
module tb_prog_loader;
    localparam int TO = 4;
    localparam int HUNT = 0, INF = 1, FIN = 2, BAD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vin [2];
    logic [7:0] din [2];

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(10)) bi0 ();
    prog_loader_if #(.ADDR_W(4))  bi1 ();

    prog_loader #(.ADDR_W(10), .TIMEOUT(TO)) dut0 (.clk(clk), .rst(rst), .bus(bi0));
    prog_loader #(.ADDR_W(4),  .TIMEOUT(TO)) dut1 (.clk(clk), .rst(rst), .bus(bi1));

    assign bi0.in_valid = vin[0];
    assign bi0.in_data  = din[0];
    assign bi1.in_valid = vin[1];
    assign bi1.in_data  = din[1];

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endfunction

    // Reference model: tracks byte position inside the frame rather than named states.
    int         st [2], pos [2], nw [2], idl [2], wd [2], dep [2];
    logic [7:0] xr [2];
    int         e_we [2], e_addr [2], e_wd [2];

    initial begin
        dep[0] = 1024;
        dep[1] = 16;
    end

    function automatic void step(int l, logic v, logic [7:0] d);
        int k;
        if (!rst) begin
            st[l] = HUNT; pos[l] = 0; idl[l] = 0; xr[l] = 8'h00;
            e_we[l] = 0; e_addr[l] = 0; e_wd[l] = 0;
            return;
        end
        e_we[l] = 0;
        if (st[l] != INF) begin
            if (v && d == 8'hA5) begin
                st[l] = INF; pos[l] = 0; idl[l] = 0;
            end
        end else if (v) begin
            idl[l] = 0;
            if (pos[l] == 0) begin
                nw[l] = int'(d) * 256; xr[l] = d;
            end else if (pos[l] == 1) begin
                nw[l] = nw[l] + int'(d); xr[l] = xr[l] ^ d;
                if (nw[l] == 0 || nw[l] > dep[l]) st[l] = BAD;
            end else if (pos[l] < 2 + 3 * nw[l]) begin
                k = pos[l] - 2;
                xr[l] = xr[l] ^ d;
                case (k % 3)
                    0: if (d > 8'd7) st[l] = BAD; else wd[l] = int'(d) * 65536;
                    1: wd[l] = wd[l] + int'(d) * 256;
                    default: begin
                        wd[l] = wd[l] + int'(d);
                        e_we[l] = 1; e_addr[l] = k / 3; e_wd[l] = wd[l];
                    end
                endcase
            end else begin
                st[l] = (d == xr[l]) ? FIN : BAD;
            end
            pos[l]++;
        end else begin
            idl[l]++;
            if (idl[l] == TO) st[l] = BAD;
        end
    endfunction

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) step(l, vin[l], din[l]);
    end

    int log_a0 [$], log_d0 [$], log_a1 [$];

    always @(negedge clk) begin
        int a_we [2], a_addr [2], a_wd [2], a_dn [2], a_er [2], a_cr [2], a_rd [2];
        a_we[0] = int'(bi0.im_we); a_addr[0] = int'(bi0.im_addr); a_wd[0] = int'(bi0.im_wdata);
        a_dn[0] = int'(bi0.done);  a_er[0] = int'(bi0.error);     a_cr[0] = int'(bi0.cpu_rst_n);
        a_rd[0] = int'(bi0.in_ready);
        a_we[1] = int'(bi1.im_we); a_addr[1] = int'(bi1.im_addr); a_wd[1] = int'(bi1.im_wdata);
        a_dn[1] = int'(bi1.done);  a_er[1] = int'(bi1.error);     a_cr[1] = int'(bi1.cpu_rst_n);
        a_rd[1] = int'(bi1.in_ready);
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("lane%0d im_we", l),     a_we[l],   e_we[l]);
            chk($sformatf("lane%0d im_addr", l),   a_addr[l], e_addr[l]);
            chk($sformatf("lane%0d im_wdata", l),  a_wd[l],   e_wd[l]);
            chk($sformatf("lane%0d done", l),      a_dn[l],   int'(st[l] == FIN));
            chk($sformatf("lane%0d error", l),     a_er[l],   int'(st[l] == BAD));
            chk($sformatf("lane%0d cpu_rst_n", l), a_cr[l],   int'(st[l] == FIN));
            chk($sformatf("lane%0d in_ready", l),  a_rd[l],   int'(rst));
        end
        if (bi0.im_we) begin log_a0.push_back(a_addr[0]); log_d0.push_back(a_wd[0]); end
        if (bi1.im_we) log_a1.push_back(a_addr[1]);
    end

    logic [7:0] fq [$];
    int         wq [$];

    task automatic send(int l, logic [7:0] b, int gap);
        repeat (gap) begin @(posedge clk); #1; vin[l] = 1'b0; din[l] = 8'($urandom); end
        @(posedge clk); #1; vin[l] = 1'b1; din[l] = b;
    endtask

    task automatic idle(int l, int c);
        repeat (c) begin @(posedge clk); #1; vin[l] = 1'b0; din[l] = 8'($urandom); end
    endtask

    task automatic send_fq(int l, int maxgap);
        foreach (fq[i]) send(l, fq[i], (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
    endtask

    // Builds a frame from wq; flip corrupts the checksum, bad_b0 sets a reserved B0 bit.
    task automatic mk(logic [7:0] flip, bit bad_b0);
        logic [7:0] x, b;
        int n;
        n = wq.size();
        fq.delete();
        fq.push_back(8'hA5);
        fq.push_back(8'(n >> 8));
        fq.push_back(8'(n));
        x = 8'(n >> 8) ^ 8'(n);
        foreach (wq[i]) begin
            b = 8'(wq[i] >> 16);
            if (bad_b0 && i == 0) b = b | 8'h10;
            fq.push_back(b);                x = x ^ b;
            fq.push_back(8'(wq[i] >> 8));   x = x ^ 8'(wq[i] >> 8);
            fq.push_back(8'(wq[i]));        x = x ^ 8'(wq[i]);
        end
        fq.push_back(x ^ flip);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vin[0] = 1'b0; vin[1] = 1'b0; din[0] = 8'h00; din[1] = 8'h00;
        rst = 1'b0;
        idle(0, 3);
        chk("reset in_ready", int'(bi0.in_ready), 0);
        chk("reset cpu_rst_n", int'(bi0.cpu_rst_n), 0);
        @(posedge clk); #1; rst = 1'b1;

        // Good load
        log_a0.delete(); log_d0.delete();
        fq = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06, 8'h78, 8'h9A, 8'h81};
        send_fq(0, 0); idle(0, 2);
        chk("good writes", log_a0.size(), 2);
        if (log_a0.size() == 2) begin
            chk("good addr0", log_a0[0], 0);  chk("good data0", log_d0[0], 'h12345);
            chk("good addr1", log_a0[1], 1);  chk("good data1", log_d0[1], 'h6789A);
        end
        chk("good done", int'(bi0.done), 1);
        chk("good cpu_rst_n", int'(bi0.cpu_rst_n), 1);
        chk("good error", int'(bi0.error), 0);

        // Bad checksum, then a good frame
        log_a0.delete();
        fq = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06, 8'h78, 8'h9A, 8'h80};
        send_fq(0, 0); idle(0, 2);
        chk("badchk writes", log_a0.size(), 2);
        chk("badchk error", int'(bi0.error), 1);
        chk("badchk cpu_rst_n", int'(bi0.cpu_rst_n), 0);
        fq = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06, 8'h78, 8'h9A, 8'h81};
        send_fq(0, 0); idle(0, 2);
        chk("recover done", int'(bi0.done), 1);

        // Format errors
        log_a0.delete();
        fq = {8'hA5, 8'h00, 8'h00}; send_fq(0, 0); idle(0, 2);
        chk("len0 error", int'(bi0.error), 1);
        fq = {8'hA5, 8'h04, 8'h01}; send_fq(0, 0); idle(0, 2);
        chk("len1025 error", int'(bi0.error), 1);
        fq = {8'hA5, 8'h00, 8'h01, 8'h08}; send_fq(0, 0); idle(0, 2);
        chk("b0 error", int'(bi0.error), 1);
        chk("format no writes", log_a0.size(), 0);

        // Timeout boundary
        fq = {8'hA5, 8'h00, 8'h01, 8'h01, 8'h23}; send_fq(0, 0);
        send(0, 8'h45, 3); send(0, 8'h66, 0); idle(0, 2);
        chk("tmo3 done", int'(bi0.done), 1);
        log_a0.delete();
        fq = {8'hA5, 8'h00, 8'h01, 8'h01, 8'h23}; send_fq(0, 0);
        idle(0, 4);
        chk("tmo before limit", int'(bi0.error), 0);
        idle(0, 1);
        chk("tmo4 error", int'(bi0.error), 1);
        idle(0, 2);
        chk("tmo4 no write", log_a0.size(), 0);

        // Reset mid-frame, then garbage before a good frame
        fq = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06}; send_fq(0, 0);
        @(posedge clk); #1; rst = 1'b0; vin[0] = 1'b0;
        log_a0.delete();
        idle(0, 2);
        chk("rst im_we", int'(bi0.im_we), 0);
        chk("rst im_addr", int'(bi0.im_addr), 0);
        chk("rst done", int'(bi0.done), 0);
        chk("rst in_ready", int'(bi0.in_ready), 0);
        chk("rst no write", log_a0.size(), 0);
        @(posedge clk); #1; rst = 1'b1;
        fq = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06, 8'h78, 8'h9A, 8'h81};
        send_fq(0, 0); idle(0, 2);
        chk("garbage done", int'(bi0.done), 1);

        // Full depth on the 16-word instance
        wq.delete();
        for (int i = 0; i < 16; i++) wq.push_back(int'($urandom & 32'h7FFFF));
        mk(8'h00, 1'b0);
        send_fq(1, 2); idle(1, 2);
        chk("full writes", log_a1.size(), 16);
        if (log_a1.size() > 0) chk("full last addr", log_a1[log_a1.size() - 1], 15);
        chk("full done", int'(bi1.done), 1);

        // Randomized frames checked cycle-by-cycle against the model
        for (int f = 0; f < 40; f++) begin
            int n, mg;
            logic [7:0] flip;
            wq.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) wq.push_back(int'($urandom & 32'h7FFFF));
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            mk(flip, $urandom_range(0, 7) == 0);
            mg = ($urandom_range(0, 4) == 0) ? TO : TO - 1;
            send_fq(0, mg);
            idle(0, $urandom_range(1, 3));
        end
        idle(0, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
